// File: rtl/spi_slave_if_if.sv
// Bus bundle between the SPI pad side / RAM and the serial front end.
// The slave modport is the front end itself; master is the pads-plus-RAM side.
interface spi_slave_if_if #(
    parameter int DWIDTH = 8
);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DWIDTH+1:0] rx_data;
    logic              rx_valid;
    logic [DWIDTH-1:0] tx_data;
    logic              tx_valid;
    logic              frame_err;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, frame_err
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, frame_err
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave serial front end: MOSI frames -> {op, payload} command words,
// RAM read data -> MISO. Runs entirely on the SPI serial clock.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | waiting for SS_n low
//  CHK_CMD   | sampling the command bit, picking the frame type
//  WRITE     | shifting a write word (addr or data)
//  READ_ADD  | shifting a read-address word
//  READ_DATA | shifting a read-data word, then returning RAM data on MISO
module spi_slave_if #(
    parameter int DWIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    spi_slave_if_if.slave bus
);
    localparam int WW = DWIDTH + 2;
    localparam int CW = $clog2(WW);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    logic [2:0]        state;
    logic [CW-1:0]     bit_cnt;
    logic [WW-2:0]     shreg;
    logic              word_done;
    logic              rd_pending;
    logic              tx_arm;
    logic              tx_loaded;
    logic [CW-1:0]     tx_left;
    logic [DWIDTH-1:0] tx_sh;

    logic [WW-1:0]     w_next;
    logic              word_ok;

    always_comb begin
        w_next  = {shreg, bus.MOSI};
        word_ok = 1'b0;
        case (state)
            WRITE:     word_ok = ~w_next[WW-1];
            READ_ADD:  word_ok = (w_next[WW-1 -: 2] == 2'b10);
            READ_DATA: word_ok = (w_next[WW-1 -: 2] == 2'b11);
            default:   word_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            word_done     <= 1'b0;
            rd_pending    <= 1'b0;
            tx_arm        <= 1'b0;
            tx_loaded     <= 1'b0;
            tx_left       <= '0;
            tx_sh         <= '0;
            bus.MISO      <= 1'b0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            if (bus.SS_n) begin
                state     <= IDLE;
                word_done <= 1'b0;
                tx_arm    <= 1'b0;
                tx_loaded <= 1'b0;
                tx_left   <= '0;
                bus.MISO  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= CHK_CMD;
                        word_done <= 1'b0;
                        tx_arm    <= 1'b0;
                        tx_loaded <= 1'b0;
                        tx_left   <= '0;
                        bus.MISO  <= 1'b0;
                    end
                    CHK_CMD: begin
                        if (!bus.MOSI)      state <= WRITE;
                        else if (rd_pending) state <= READ_DATA;
                        else                state <= READ_ADD;
                        bit_cnt <= CW'(WW - 1);
                    end
                    default: begin
                        if (!word_done) begin
                            shreg   <= w_next[WW-2:0];
                            bit_cnt <= bit_cnt - 1'b1;
                            if (bit_cnt == '0) begin
                                word_done <= 1'b1;
                                if (word_ok) begin
                                    bus.rx_data  <= w_next;
                                    bus.rx_valid <= 1'b1;
                                    if (state == READ_ADD)  rd_pending <= 1'b1;
                                    if (state == READ_DATA) begin
                                        rd_pending <= 1'b0;
                                        tx_arm     <= 1'b1;
                                    end
                                end else begin
                                    bus.frame_err <= 1'b1;
                                end
                            end
                        end else if (tx_arm) begin
                            // tx_data is captured once per frame; later tx_valid highs are ignored
                            if (!tx_loaded) begin
                                if (bus.tx_valid) begin
                                    tx_sh     <= bus.tx_data;
                                    tx_left   <= CW'(DWIDTH);
                                    tx_loaded <= 1'b1;
                                end
                            end else if (tx_left != '0) begin
                                bus.MISO <= tx_sh[DWIDTH-1];
                                tx_sh    <= {tx_sh[DWIDTH-2:0], 1'b0};
                                tx_left  <= tx_left - 1'b1;
                            end else begin
                                bus.MISO <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: frame driver pushes expected strobes,
// a negedge monitor pops and checks them; read data is checked bit by bit.
module tb_spi_slave_if;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    int   cyc;
    logic miso_window;
    logic [9:0] last_rx;

    typedef struct {
        int         kind;   // 1 = rx_valid, 2 = frame_err
        logic [9:0] data;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    spi_slave_if_if #(.DWIDTH(8)) bus ();

    spi_slave_if #(.DWIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid || bus.frame_err) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_strobe", 32'({bus.frame_err, bus.rx_valid}), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("strobe_kind", 32'({bus.frame_err, bus.rx_valid}), 32'(e.kind));
                    check_eq("strobe_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.kind == 1) check_eq("rx_data", 32'(bus.rx_data), 32'(e.data));
                end
            end
            if (!miso_window) check_eq("miso_idle", 32'(bus.MISO), 32'd0);
        end
    end

    // kind: 0 none (abort), 1 valid word, 2 op mismatch
    task automatic frame(input logic cmd, input logic [9:0] w, input int nbits,
                         input int kind, input int extra, input bit keep);
        exp_t e;
        @(negedge clk); bus.SS_n = 1'b0; bus.MOSI = 1'b0;
        @(negedge clk); bus.MOSI = cmd;
        for (int i = 9; i >= 10 - nbits; i--) begin
            @(negedge clk); bus.MOSI = w[i];
            if (i == 0 && kind != 0) begin
                e.kind = kind; e.data = w; e.cyc = cyc + 1;
                sb.push_back(e);
                if (kind == 1) last_rx = w;
            end
        end
        for (int i = 0; i < extra; i++) begin
            @(negedge clk); bus.MOSI = 1'b1;
        end
        if (!keep) begin
            @(negedge clk); bus.SS_n = 1'b1; bus.MOSI = 1'b0;
        end
    endtask

    task automatic read_out(input logic [7:0] d, input bit do_rst);
        repeat (3) @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_data = d; miso_window = 1'b1;
        @(negedge clk);
        bus.tx_data = ~d;
        check_eq("miso_load", 32'(bus.MISO), 32'd0);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            check_eq("miso_bit", 32'(bus.MISO), 32'(d[i]));
            if (do_rst) begin
                #1 rst_n = 1'b0;
                #1;
                check_eq("rst_miso", 32'(bus.MISO), 32'd0);
                check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
                check_eq("rst_frame_err", 32'(bus.frame_err), 32'd0);
                check_eq("rst_rx_data", 32'(bus.rx_data), 32'd0);
                last_rx = '0;
                bus.tx_valid = 1'b0; bus.SS_n = 1'b1; miso_window = 1'b0;
                @(negedge clk); rst_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        check_eq("miso_end", 32'(bus.MISO), 32'd0);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        miso_window = 1'b0;
        bus.SS_n = 1'b1;
    endtask

    task automatic reset_pulse();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fails = 0; cyc = 0; miso_window = 1'b0; last_rx = '0;
        rst_n = 1'b0;
        bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_data = '0; bus.tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_miso", 32'(bus.MISO), 32'd0);
        check_eq("reset_rx_data", 32'(bus.rx_data), 32'd0);
        check_eq("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_eq("reset_frame_err", 32'(bus.frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        frame(1'b0, 10'h03C, 10, 1, 0, 1'b0);          // write address
        frame(1'b0, 10'h1A5, 10, 1, 3, 1'b0);          // write data, trailing bits ignored
        frame(1'b1, 10'h23C, 10, 1, 0, 1'b0);          // read address -> rd_pending
        frame(1'b1, 10'h300, 10, 1, 0, 1'b1);          // read data
        read_out(8'hA5, 1'b0);
        frame(1'b1, 10'h0FF, 10, 2, 0, 1'b0);          // op mismatch in READ_ADD
        @(negedge clk);
        check_eq("err_rx_data_held", 32'(bus.rx_data), 32'(last_rx));
        frame(1'b0, 10'h2FF, 10, 2, 0, 1'b0);          // op mismatch in WRITE
        frame(1'b0, 10'h155, 5, 0, 0, 1'b0);           // abort after 5 bits
        frame(1'b0, 10'h155, 10, 1, 0, 1'b0);
        frame(1'b1, 10'h2C3, 10, 1, 0, 1'b0);          // rd_pending set
        frame(1'b1, 10'h35A, 10, 1, 0, 1'b1);
        read_out(8'h5A, 1'b0);
        frame(1'b1, 10'h211, 10, 1, 0, 1'b0);
        frame(1'b1, 10'h322, 10, 1, 0, 1'b1);
        read_out(8'hC3, 1'b1);                         // reset during MISO shift
        frame(1'b1, 10'h2AA, 10, 1, 0, 1'b0);          // rd_pending set, then reset
        reset_pulse();
        last_rx = '0;
        frame(1'b1, 10'h277, 10, 1, 0, 1'b0);          // must decode as READ_ADD
        repeat (4) @(negedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
